// File: rtl/alu_pkg.sv
// Shared definitions for the ALU scheduler: opcode encodings, flag bit
// positions within the {CF,ZF,SF,OF} flag vector, and the scheduler FSM states.
package alu_pkg;

  localparam logic [2:0] ADD = 3'd0;
  localparam logic [2:0] SUB = 3'd1;
  localparam logic [2:0] NOT = 3'd2;
  localparam logic [2:0] AND = 3'd3;
  localparam logic [2:0] OR  = 3'd4;
  localparam logic [2:0] XOR = 3'd5;
  localparam logic [2:0] LT  = 3'd6;
  localparam logic [2:0] EQ  = 3'd7;

  localparam int unsigned CF = 3;
  localparam int unsigned ZF = 2;
  localparam int unsigned SF = 1;
  localparam int unsigned OF = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_rr_arb.sv
// Two-way arbiter for the ALU scheduler.
// Configuration macro: ALU_SCHED_RR_EN
//   defined   -> round-robin; a pointer flop picks the winner of a tie and
//                moves to the other requester after every grant.
//   undefined -> fixed priority, requester 0 wins every tie; no state at all.
module alu_rr_arb (
`ifdef ALU_SCHED_RR_EN
  input  logic clk,
  input  logic rst,
  input  logic take,
`endif
  input  logic valid0,
  input  logic valid1,
  output logic gnt_vld,
  output logic gnt_id
);

`ifdef ALU_SCHED_RR_EN
  logic ptr_q, ptr_d;

  // Grant selection: pointer breaks ties, a lone requester always wins.
  always_comb begin
    gnt_vld = valid0 | valid1;
    if (valid0 && valid1) gnt_id = ptr_q;
    else                  gnt_id = valid1;
    ptr_d = ptr_q;
    if (take) ptr_d = ~gnt_id;
  end

  // Pointer register; reset favours requester 0, moves only on a grant.
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= 1'b0;
    else     ptr_q <= ptr_d;
  end
`else
  // Fixed priority: requester 1 wins only when requester 0 is idle.
  always_comb begin
    gnt_vld = valid0 | valid1;
    gnt_id  = ~valid0 & valid1;
  end
`endif

endmodule

// File: rtl/alu_sched.sv
// Schedules operations from two requesters onto one shared external
// combinational ALU. One operation in flight at a time: IDLE accepts,
// EXEC captures the ALU result, RESP holds it until the consumer takes it.
// Configuration macro: ALU_SCHED_RR_EN selects round-robin arbitration
// (default build: fixed priority to requester 0).
module alu_sched
  import alu_pkg::*;
#(
  parameter int W   = 4,
  parameter int OPW = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [OPW-1:0] req0_op,
  input  logic [W-1:0]   req0_a,
  input  logic [W-1:0]   req0_b,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [OPW-1:0] req1_op,
  input  logic [W-1:0]   req1_a,
  input  logic [W-1:0]   req1_b,
  output logic [OPW-1:0] alu_op,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  input  logic [W-1:0]   alu_value,
  input  logic [3:0]     alu_flags,
  output logic           resp_valid,
  input  logic           resp_ready,
  output logic           resp_id,
  output logic [W-1:0]   resp_value,
  output logic [3:0]     resp_flags,
  output logic           busy
);

  state_t         state_q, state_d;
  logic           gnt_vld, gnt_id, accept;
  logic           id_q, id_d;
  logic [OPW-1:0] alu_op_q, alu_op_d;
  logic [W-1:0]   alu_a_q, alu_a_d;
  logic [W-1:0]   alu_b_q, alu_b_d;
  logic [W-1:0]   resp_value_q, resp_value_d;
  logic [3:0]     resp_flags_q, resp_flags_d;

  alu_rr_arb u_arb (
`ifdef ALU_SCHED_RR_EN
    .clk     (clk),
    .rst     (rst),
    .take    (accept),
`endif
    .valid0  (req0_valid),
    .valid1  (req1_valid),
    .gnt_vld (gnt_vld),
    .gnt_id  (gnt_id)
  );

  // A transfer happens only in IDLE; reset suppresses any handshake.
  assign accept = (state_q == IDLE) && gnt_vld && !rst;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: ready only to the granted, valid requester while IDLE.
  always_comb begin
    req0_ready = accept && !gnt_id;
    req1_ready = accept &&  gnt_id;
    resp_valid = (state_q == RESP);
    busy       = (state_q != IDLE);
  end

  // Operand latch on accept, result capture in EXEC; otherwise hold.
  always_comb begin
    id_d         = id_q;
    alu_op_d     = alu_op_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    resp_value_d = resp_value_q;
    resp_flags_d = resp_flags_q;
    if (accept) begin
      id_d     = gnt_id;
      alu_op_d = gnt_id ? req1_op : req0_op;
      alu_a_d  = gnt_id ? req1_a  : req0_a;
      alu_b_d  = gnt_id ? req1_b  : req0_b;
    end
    if (state_q == EXEC) begin
      resp_value_d = alu_value;
      resp_flags_d = alu_flags;
    end
  end

  // Operand and result registers, cleared so nothing stale leaks after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_q         <= 1'b0;
      alu_op_q     <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      resp_value_q <= '0;
      resp_flags_q <= '0;
    end else begin
      id_q         <= id_d;
      alu_op_q     <= alu_op_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      resp_value_q <= resp_value_d;
      resp_flags_q <= resp_flags_d;
    end
  end

  assign alu_op     = alu_op_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign resp_id    = id_q;
  assign resp_value = resp_value_q;
  assign resp_flags = resp_flags_q;

endmodule

// File: tb/tb_alu_sched.sv
// Directed testbench for alu_sched with a behavioural 4-bit ALU attached.
// Arbitration expectations follow ALU_SCHED_RR_EN.
module tb_alu_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [2:0] req0_op, req1_op, alu_op;
  logic [3:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, alu_value;
  logic [3:0] alu_flags, resp_flags, resp_value;
  logic       resp_valid, resp_ready, resp_id, busy;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  alu_sched #(.W(4), .OPW(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_value  (alu_value),
    .alu_flags  (alu_flags),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_value (resp_value),
    .resp_flags (resp_flags),
    .busy       (busy)
  );

  // External combinational ALU; flags are {CF,ZF,SF,OF}.
  always_comb begin
    logic [4:0] s;
    logic       cf, of;
    s  = 5'd0;
    cf = 1'b0;
    of = 1'b0;
    case (alu_op)
      3'd0: begin
        s  = {1'b0, alu_a} + {1'b0, alu_b};
        cf = s[4];
        of = (alu_a[3] == alu_b[3]) && (s[3] != alu_a[3]);
      end
      3'd1: begin
        s  = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'd1;
        cf = s[4];
        of = (alu_a[3] != alu_b[3]) && (s[3] != alu_a[3]);
      end
      3'd2:    s = {1'b0, ~alu_a};
      3'd3:    s = {1'b0, alu_a & alu_b};
      3'd4:    s = {1'b0, alu_a | alu_b};
      3'd5:    s = {1'b0, alu_a ^ alu_b};
      3'd6:    s = {4'd0, alu_a < alu_b};
      default: s = {4'd0, alu_a == alu_b};
    endcase
    alu_value = s[3:0];
    alu_flags = {cf, (s[3:0] == 4'd0), s[3], of};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic exp_id [4];

  initial begin
`ifdef ALU_SCHED_RR_EN
    exp_id[0] = 1'b0; exp_id[1] = 1'b1; exp_id[2] = 1'b0; exp_id[3] = 1'b1;
`else
    exp_id[0] = 1'b0; exp_id[1] = 1'b0; exp_id[2] = 1'b0; exp_id[3] = 1'b0;
`endif
    rst = 1'b1;
    req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
    req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
    resp_ready = 1'b1;
    step(); step();

    // Reset state
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_resp_value", resp_value, 0);
    chk("rst_resp_flags", resp_flags, 0);
    rst = 1'b0;

    // req0 ADD 7+1: accept, response visible one edge later, gone after take
    req0_valid = 1; req0_op = 3'd0; req0_a = 4'd7; req0_b = 4'd1;
    #1;
    chk("add_ready0", req0_ready, 1);
    chk("add_ready1", req1_ready, 0);
    step();
    req0_valid = 0;
    chk("add_alu_a", alu_a, 7);
    chk("add_alu_b", alu_b, 1);
    chk("add_busy", busy, 1);
    chk("add_rv_exec", resp_valid, 0);
    step();
    chk("add_rv", resp_valid, 1);
    chk("add_id", resp_id, 0);
    chk("add_value", resp_value, 8);
    chk("add_flags", resp_flags, 4'b0011);
    step();
    chk("add_rv_drop", resp_valid, 0);
    chk("add_idle", busy, 0);

    // req1 SUB 3-3
    req1_valid = 1; req1_op = 3'd1; req1_a = 4'd3; req1_b = 4'd3;
    #1;
    chk("sub_ready1", req1_ready, 1);
    step();
    req1_valid = 0;
    step();
    chk("sub_rv", resp_valid, 1);
    chk("sub_id", resp_id, 1);
    chk("sub_value", resp_value, 0);
    chk("sub_flags", resp_flags, 4'b1100);
    step();

    // Both requesters valid for four operations
    req0_valid = 1; req0_op = 3'd0; req0_a = 4'd2; req0_b = 4'd3;
    req1_valid = 1; req1_op = 3'd5; req1_a = 4'd5; req1_b = 4'd3;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("arb_ready0", req0_ready, !exp_id[i]);
      chk("arb_ready1", req1_ready, exp_id[i]);
      step();
      step();
      chk("arb_id", resp_id, exp_id[i]);
      chk("arb_value", resp_value, exp_id[i] ? 4'd6 : 4'd5);
      step();
    end
    req0_valid = 0; req1_valid = 0;

    // Backpressure: AND 12&10 held in RESP for five cycles
    resp_ready = 0;
    req0_valid = 1; req0_op = 3'd3; req0_a = 4'd12; req0_b = 4'd10;
    step();
    req0_valid = 0;
    step();
    req1_valid = 1; req1_op = 3'd7; req1_a = 4'd1; req1_b = 4'd1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rv", resp_valid, 1);
      chk("bp_value", resp_value, 8);
      chk("bp_flags", resp_flags, 4'b0010);
      chk("bp_alu_a", alu_a, 12);
      chk("bp_readies", {req0_ready, req1_ready}, 2'b00);
      step();
    end
    req1_valid = 0;
    resp_ready = 1;
    step();
    chk("bp_release_rv", resp_valid, 0);
    chk("bp_release_busy", busy, 0);

    // Reset during EXEC discards the operation
    req1_valid = 1; req1_op = 3'd4; req1_a = 4'd1; req1_b = 4'd2;
    step();
    req1_valid = 0;
    chk("rx_busy_exec", busy, 1);
    rst = 1;
    step();
    rst = 0;
    chk("rx_rv", resp_valid, 0);
    chk("rx_busy", busy, 0);
    chk("rx_alu_b", alu_b, 0);
    chk("rx_alu_op", alu_op, 0);
    chk("rx_id", resp_id, 0);
    chk("rx_value", resp_value, 0);
    step();
    chk("rx_rv_after", resp_valid, 0);

    // req0 pulsed while busy is ignored
    req1_valid = 1; req1_op = 3'd7; req1_a = 4'd4; req1_b = 4'd4;
    step();
    req1_valid = 0;
    chk("pulse_alu_op", alu_op, 7);
    req0_valid = 1; req0_op = 3'd2; req0_a = 4'd0; req0_b = 4'd0;
    #1;
    chk("pulse_ready0", req0_ready, 0);
    step();
    req0_valid = 0;
    chk("pulse_rv", resp_valid, 1);
    chk("pulse_id", resp_id, 1);
    chk("pulse_value", resp_value, 1);
    step();
    for (int i = 0; i < 3; i++) begin
      chk("pulse_quiet_rv", resp_valid, 0);
      chk("pulse_quiet_busy", busy, 0);
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
